// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings for the next-PC sequencer
//
// Purpose: run-control state encoding, trap cause codes and the
// instruction size used for sequential PC advance.
// Ports: none (package).
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - next-PC target selection with misalignment flag
//
// Purpose: picks jump target, branch target or pc+4 (jump wins over branch)
// and flags a redirect whose target is not word aligned.
// Ports:
//   pc_current    in  32  current PC
//   branch_taken  in  1   branch resolved taken
//   branch_target in  32  branch destination
//   jump          in  1   JAL/JALR
//   jump_target   in  32  jump destination
//   target        out 32  selected next PC
//   misaligned    out 1   redirect target with nonzero [1:0]
module pc_target_mux (
  input  logic [31:0] pc_current,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] target,
  output logic        misaligned
);
  import pc_sequencer_pkg::*;

  always_comb begin
    if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end else begin
      // Wraps silently at 2^32.
      target = pc_current + INSTR_BYTES;
    end
  end

  // The sequential path is always aligned by construction, so only
  // redirects are checked.
  assign misaligned = (jump || branch_taken) && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller with run-control FSM
//
// Purpose: drives pc_next of an enable-less PC register every cycle;
// holds are done by feeding pc_current back. Tracks BOOT/RUN/HALT/TRAP,
// captures the trapping PC and its cause.
// Ports:
//   clk, reset                 clock (rising), async active-high reset
//   pc_current        in  32   PC register output
//   branch_taken/_target        conditional branch request
//   jump/jump_target            jump request
//   stall             in  1    hold PC
//   halt_req          in  1    EBREAK
//   resume            in  1    leave HALT
//   illegal_instr     in  1    illegal opcode
//   pc_next           out 32   next PC (combinational)
//   fetch_valid       out 1    instruction may commit (RUN only)
//   halted            out 1    in HALT
//   epc, cause        out      last trap PC and cause
//   state             out 2    run-control state
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        illegal_instr,
  output logic [31:0] pc_next,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [1:0]  state
);
  import pc_sequencer_pkg::*;

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] boot_cnt;
  logic [31:0]   target;
  logic          misaligned;

  pc_target_mux u_target_mux (
    .pc_current    (pc_current),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      boot_cnt <= '0;
      epc      <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + CW'(1);
          if (boot_cnt == BOOT_LAST) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (illegal_instr) begin
            epc     <= pc_current;
            cause   <= CAUSE_ILLEGAL;
            state_q <= ST_TRAP;
          end else if (misaligned) begin
            epc     <= pc_current;
            cause   <= CAUSE_MISALIGN;
            state_q <= ST_TRAP;
          end else if (halt_req) begin
            state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (resume) state_q <= ST_RUN;
        end
        default: begin
          // TRAP lasts one cycle; the PC already holds TRAP_VECTOR.
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    pc_next = pc_current;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      case (state_q)
        ST_BOOT: pc_next = RESET_VECTOR;
        ST_RUN: begin
          // Traps take precedence over halt and stall.
          if (illegal_instr || misaligned) pc_next = TRAP_VECTOR;
          else if (halt_req || stall)      pc_next = pc_current;
          else                             pc_next = target;
        end
        default: pc_next = pc_current;
      endcase
    end
  end

  assign fetch_valid = !reset && (state_q == ST_RUN);
  assign halted      = !reset && (state_q == ST_HALT);
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          BC = 2;

  logic        clk;
  logic        reset;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic        illegal_instr;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [1:0]  state;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall),
    .halt_req(halt_req), .resume(resume), .illegal_instr(illegal_instr),
    .pc_next(pc_next), .fetch_valid(fetch_valid), .halted(halted),
    .epc(epc), .cause(cause), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: mode numbers follow the documented state encoding.
  int          m_mode;
  int          m_boot_done;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;

  typedef struct packed {
    logic [31:0] pc;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        st;
    logic        hr;
    logic        ill;
    logic [31:0] exp_next;
    logic [1:0]  exp_state;
    logic [31:0] exp_epc;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  task automatic clear_inputs();
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    stall = 1'b0; halt_req = 1'b0; resume = 1'b0; illegal_instr = 1'b0;
  endtask

  // The bench acts as the PC register: it loads pc_next on each edge.
  task automatic advance();
    logic [31:0] nxt;
    nxt = pc_next;
    @(posedge clk);
    #1;
    pc_current = nxt;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_inputs();
    #2;
    check({tag, " rst state"},   32'(state),       32'd0);
    check({tag, " rst pc_next"}, pc_next,          RV);
    check({tag, " rst fv"},      32'(fetch_valid), 32'd0);
    check({tag, " rst halted"},  32'(halted),      32'd0);
    check({tag, " rst epc"},     epc,              32'd0);
    check({tag, " rst cause"},   32'(cause),       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_current = RV;
    m_mode = 0; m_boot_done = 0; m_pc = RV; m_epc = '0; m_cause = '0;
  endtask

  task automatic boot();
    do_reset("boot");
    repeat (BC) begin
      @(negedge clk);
      advance();
    end
  endtask

  task automatic random_cycle(input int idx);
    logic [31:0] e_next, tgt;
    logic        e_fv;
    int          n_mode;
    branch_taken  = ($urandom_range(0, 3) == 0);
    jump          = ($urandom_range(0, 4) == 0);
    branch_target = {$urandom_range(0, 32'h3fff_ffff), 2'b00} |
                    (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    jump_target   = {$urandom_range(0, 32'h3fff_ffff), 2'b00} |
                    (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    stall         = ($urandom_range(0, 5) == 0);
    halt_req      = ($urandom_range(0, 11) == 0);
    resume        = ($urandom_range(0, 2) == 0);
    illegal_instr = ($urandom_range(0, 15) == 0);
    pc_current    = m_pc;
    @(negedge clk);
    n_mode = m_mode;
    e_next = m_pc;
    e_fv   = 1'b0;
    if (m_mode == 0) begin
      e_next = RV;
      if (m_boot_done + 1 == BC) n_mode = 1;
    end else if (m_mode == 1) begin
      e_fv = 1'b1;
      if (jump) tgt = jump_target;
      else if (branch_taken) tgt = branch_target;
      else tgt = m_pc + 32'd4;
      if (illegal_instr) begin
        e_next = TV; n_mode = 3;
      end else if ((jump || branch_taken) && (tgt % 4 != 0)) begin
        e_next = TV; n_mode = 3;
      end else if (halt_req) begin
        n_mode = 2;
      end else if (!stall) begin
        e_next = tgt;
      end
    end else if (m_mode == 2) begin
      if (resume) n_mode = 1;
    end else begin
      n_mode = 1;
    end
    check($sformatf("rnd%0d pc_next", idx), pc_next,          e_next);
    check($sformatf("rnd%0d fv", idx),      32'(fetch_valid), 32'(e_fv));
    check($sformatf("rnd%0d halted", idx),  32'(halted),      32'(m_mode == 2));
    check($sformatf("rnd%0d state", idx),   32'(state),       32'(m_mode));
    check($sformatf("rnd%0d epc", idx),     epc,              m_epc);
    check($sformatf("rnd%0d cause", idx),   32'(cause),       32'(m_cause));
    if (m_mode == 1 && n_mode == 3) begin
      m_epc   = m_pc;
      m_cause = illegal_instr ? 2'd1 : 2'd2;
    end
    if (m_mode == 0) m_boot_done++;
    m_mode = n_mode;
    m_pc   = e_next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    pc_current = '0;
    clear_inputs();

    //                pc            br  bt            j   jt            st  hr  ill exp_next      st    epc           cause
    vecs[0]  = '{32'h10,       1, 32'h80,      1, 32'h40,      0, 0, 0, 32'h40,      2'd1, 32'h0,  2'd0};
    vecs[1]  = '{32'h10,       1, 32'h80,      1, 32'h40,      1, 0, 0, 32'h10,      2'd1, 32'h0,  2'd0};
    vecs[2]  = '{32'h20,       0, 32'h0,       1, 32'h42,      0, 0, 0, TV,          2'd3, 32'h20, 2'd2};
    vecs[3]  = '{32'h30,       0, 32'h0,       0, 32'h0,       0, 1, 1, TV,          2'd3, 32'h30, 2'd1};
    vecs[4]  = '{32'h50,       0, 32'h0,       0, 32'h0,       0, 1, 0, 32'h50,      2'd2, 32'h0,  2'd0};
    vecs[5]  = '{32'hFFFF_FFFC, 0, 32'h0,      0, 32'h0,       0, 0, 0, 32'h0,       2'd1, 32'h0,  2'd0};
    vecs[6]  = '{32'h60,       1, 32'h81,      0, 32'h0,       0, 0, 0, TV,          2'd3, 32'h60, 2'd2};
    vecs[7]  = '{32'h60,       1, 32'h83,      1, 32'h70,      0, 0, 0, 32'h70,      2'd1, 32'h0,  2'd0};
    vecs[8]  = '{32'h62,       0, 32'h0,       0, 32'h0,       0, 0, 0, 32'h66,      2'd1, 32'h0,  2'd0};
    vecs[9]  = '{32'h70,       0, 32'h0,       1, 32'h71,      1, 0, 0, TV,          2'd3, 32'h70, 2'd2};
    vecs[10] = '{32'h80,       1, 32'h200,     0, 32'h0,       1, 1, 0, 32'h80,      2'd2, 32'h0,  2'd0};
    vecs[11] = '{32'h90,       1, 32'h200,     0, 32'h0,       0, 0, 0, 32'h200,     2'd1, 32'h0,  2'd0};

    // Boot sequence then sequential fetch from the reset vector.
    do_reset("seqA");
    for (int i = 0; i < BC; i++) begin
      @(negedge clk);
      check($sformatf("seqA boot%0d pc_next", i), pc_next,          RV);
      check($sformatf("seqA boot%0d fv", i),      32'(fetch_valid), 32'd0);
      check($sformatf("seqA boot%0d state", i),   32'(state),       32'd0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("seqA run%0d state", i),   32'(state),       32'd1);
      check($sformatf("seqA run%0d fv", i),      32'(fetch_valid), 32'd1);
      check($sformatf("seqA run%0d pc_cur", i),  pc_current,       32'(4 * i));
      check($sformatf("seqA run%0d pc_next", i), pc_next,          32'(4 * (i + 1)));
      advance();
    end

    // Single-cycle vectors from a fresh boot.
    for (int i = 0; i < 12; i++) begin
      boot();
      pc_current    = vecs[i].pc;
      branch_taken  = vecs[i].br;  branch_target = vecs[i].bt;
      jump          = vecs[i].j;   jump_target   = vecs[i].jt;
      stall         = vecs[i].st;  halt_req      = vecs[i].hr;
      illegal_instr = vecs[i].ill;
      @(negedge clk);
      check($sformatf("vec%0d pc_next", i), pc_next, vecs[i].exp_next);
      advance();
      clear_inputs();
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d epc", i),   epc,        vecs[i].exp_epc);
      check($sformatf("vec%0d cause", i), 32'(cause), 32'(vecs[i].exp_cause));
    end

    // Misaligned jump trap, one TRAP cycle, then run from the trap vector.
    boot();
    pc_current = 32'h20; jump = 1'b1; jump_target = 32'h42;
    @(negedge clk);
    check("seqB redirect", pc_next, TV);
    advance();
    clear_inputs();
    check("seqB state trap", 32'(state),       32'd3);
    check("seqB fv trap",    32'(fetch_valid), 32'd0);
    check("seqB epc",        epc,              32'h20);
    check("seqB cause",      32'(cause),       32'd2);
    @(negedge clk);
    check("seqB trap hold", pc_next, TV);
    advance();
    check("seqB state run", 32'(state), 32'd1);
    @(negedge clk);
    check("seqB pc 104", pc_next, TV + 32'd4);
    advance();
    @(negedge clk);
    check("seqB pc 108", pc_next, TV + 32'd8);
    advance();

    // Halt for five cycles, resume re-executes the held PC, then reset in HALT.
    pc_current = 32'h50; halt_req = 1'b1;
    @(negedge clk);
    check("seqC halt pc_next", pc_next, 32'h50);
    advance();
    halt_req = 1'b0;
    illegal_instr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("seqC halt%0d halted", i),  32'(halted),      32'd1);
      check($sformatf("seqC halt%0d pc_next", i), pc_next,          32'h50);
      check($sformatf("seqC halt%0d fv", i),      32'(fetch_valid), 32'd0);
      advance();
    end
    illegal_instr = 1'b0;
    resume = 1'b1;
    @(negedge clk);
    check("seqC resume pc_next", pc_next, 32'h50);
    advance();
    resume = 1'b0;
    check("seqC resumed state", 32'(state), 32'd1);
    check("seqC epc kept",      epc,        32'h20);
    check("seqC cause kept",    32'(cause), 32'd2);
    @(negedge clk);
    check("seqC rerun pc_cur",  pc_current, 32'h50);
    check("seqC rerun pc_next", pc_next,    32'h54);
    advance();
    halt_req = 1'b1;
    @(negedge clk);
    advance();
    halt_req = 1'b0;
    check("seqC halted again", 32'(halted), 32'd1);
    do_reset("seqC");

    // Randomized run against the reference model, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd");
      random_cycle(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the single-cycle RISC-V core; drives the program counter register's pc_next input every cycle.
- Selects among sequential (pc+4), branch target, jump target, trap vector and hold.
- Owns a small run-control FSM (BOOT/RUN/HALT/TRAP), exception PC capture and misaligned-target detection.
- The program counter register has no enable, so every hold is implemented by driving pc_next = pc_current.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value driven during BOOT; must equal the PC register's reset value.
TRAP_VECTOR, 32'h0000_0100, redirect target on any trap.
BOOT_CYCLES, 2, cycles spent in BOOT after reset deasserts (>=1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
pc_current  in  32  current PC from the program counter register
branch_taken  in  1  conditional branch resolved taken this cycle
branch_target  in  32  branch destination
jump  in  1  JAL/JALR this cycle
jump_target  in  32  jump destination (JALR LSB already cleared by datapath)
stall  in  1  hold PC this cycle
halt_req  in  1  EBREAK decoded
resume  in  1  leave HALT
illegal_instr  in  1  decoder flagged illegal opcode
pc_next  out  32  next PC to the program counter register (combinational)
fetch_valid  out  1  current instruction may commit (0 in BOOT/HALT/TRAP)
halted  out  1  state == HALT
epc  out  32  PC of the last trapping instruction
cause  out  2  0 none, 1 illegal instruction, 2 misaligned target
state  out  2  BOOT=0, RUN=1, HALT=2, TRAP=3

Behaviour:
- Reset (async, any state, mid-operation included): state=BOOT, boot_cnt=0, epc=0, cause=0. Outputs during reset: pc_next=RESET_VECTOR, fetch_valid=0, halted=0.
- BOOT:
  - pc_next=RESET_VECTOR; fetch_valid=0.
  - boot_cnt increments each cycle; at boot_cnt==BOOT_CYCLES-1 next state is RUN.
  - All request inputs are ignored.
- RUN: fetch_valid=1. Selected target = jump_target if jump, else branch_target if branch_taken, else pc_current+4 (mod 2^32, wrap silently).
- RUN priority, highest first:
  1. illegal_instr: pc_next=TRAP_VECTOR; epc<=pc_current; cause<=1; ->TRAP.
  2. (jump|branch_taken) and selected target[1:0]!=0: pc_next=TRAP_VECTOR; epc<=pc_current; cause<=2; ->TRAP.
  3. halt_req: pc_next=pc_current; ->HALT.
  4. stall: pc_next=pc_current; stay in RUN.
  5. Otherwise pc_next=selected target.
- Simultaneous events:
  - Trap beats halt and stall; stall does not mask a trap.
  - jump and branch_taken both high: jump wins.
  - Sequential pc+4 is never checked for misalignment.
- TRAP: exactly one cycle; fetch_valid=0; pc_next=pc_current (PC already holds TRAP_VECTOR); ->RUN. cause/epc hold until the next trap or reset.
- HALT:
  - fetch_valid=0; pc_next=pc_current.
  - resume -> RUN next cycle; the first RUN cycle re-executes the held PC.
  - halt_req ignored while in HALT; illegal_instr ignored outside RUN.
- Latency: pc_next is combinational from inputs/state; the PC updates on the following clock edge. State/epc/cause are registered.

Decomposition:
- Shared package: state encoding (ST_BOOT..ST_TRAP), cause codes (CAUSE_NONE/ILLEGAL/MISALIGN), instruction width 4.
- Optional sub-module pc_target_mux: combinational target selection plus misalign flag. The FSM and registers stay in pc_sequencer.

Test Plan:
1. Reset, then release with BOOT_CYCLES=2 -> pc_next=0, fetch_valid=0 for 2 cycles; state=RUN on cycle 3; PC sequence 0,4,8,12.
2. At PC=0x10, branch_taken=1 and jump=1, jump_target=0x40, branch_target=0x80 -> pc_next=0x40. Repeat with stall=1 -> pc_next=0x10 held.
3. At PC=0x20, jump=1, jump_target=0x42 -> pc_next=0x100, epc=0x20, cause=2, one TRAP cycle with fetch_valid=0, then RUN at 0x104 sequence.
4. At PC=0x30, illegal_instr=1 and halt_req=1 together -> trap wins: epc=0x30, cause=1, state TRAP then RUN; no HALT.
5. At PC=0x50, halt_req=1 -> PC holds at 0x50 with halted=1 for 5 cycles; resume=1 -> RUN, next PCs 0x50, 0x54.
6. PC=0xFFFF_FFFC sequential -> pc_next=0x0000_0000. Assert reset while in HALT -> immediately state=BOOT, epc=0, cause=0, halted=0.
